if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS32 pipeline.
- Owns the PC register, drives the address of the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register.
- Selects the next PC from three sources: sequential PC+4, the ID-stage branch/jump redirect, and the exception vector.
- Honours stall from the hazard unit and supports a counter of delivered instructions.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
EXC_VECTOR, 32'h00000080, PC loaded on exception redirect.
COUNT_W, 32, width of fetched-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
Stall  input  1  hazard unit: hold PC and IF/ID.
Redirect_Valid  input  1  ID stage: taken branch or jump resolved this cycle.
Redirect_Target  input  32  ID stage target address.
Exc_Valid  input  1  exception/interrupt redirect request.
Inst_Addr  output  32  current PC, to instruction ROM Addr.
Inst_In  input  32  instruction word returned combinationally by ROM.
IF_ID_Inst  output  32  registered instruction for ID.
IF_ID_PC_Plus4  output  32  registered PC+4 of that instruction.
IF_ID_Valid  output  1  registered: IF_ID_Inst is a real instruction.
Fetch_Count  output  COUNT_W  number of valid instructions delivered to ID.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - PC=RESET_PC, so Inst_Addr=RESET_PC.
  - IF_ID_Inst=0, IF_ID_PC_Plus4=0, IF_ID_Valid=0, Fetch_Count=0.
- Inst_Addr = PC, combinational from the register; zero-latency ROM assumed.
- PC[1:0] is always 00. Low two bits of Redirect_Target are ignored.
- Per rising edge, priority highest first:
  1. Exc_Valid=1:
     - PC<=EXC_VECTOR.
     - IF/ID loads bubble (Inst=0, PC_Plus4=0, Valid=0).
     - Overrides Stall and Redirect_Valid.
  2. Stall=1:
     - PC, IF/ID and Fetch_Count hold.
     - Redirect_Valid is ignored, because ID re-presents the branch next cycle.
  3. Redirect_Valid=1:
     - PC<=Redirect_Target.
     - IF/ID handling of the instruction currently at PC is set by the optional feature below.
  4. Otherwise:
     - PC<=PC+4.
     - IF/ID<= {Inst_In, PC+4, Valid=1}.
- PC+4 is a 32-bit add that wraps modulo 2^32 (32'hFFFFFFFC -> 0).
- Fetch_Count increments by 1 on every edge where IF_ID_Valid is loaded with 1. It wraps at 2^COUNT_W.
- Reset asserted mid-operation aborts any pending redirect. The first fetch after release is at RESET_PC.
- Redirect to the current PC is legal and refetches the same word.
- Small FSM (state register, reset state BOOT):
  - BOOT: first edge after reset release. IF/ID stays invalid while the ROM output settles. Then go to RUN.
  - RUN: normal operation.
  - From any state, Exc_Valid leads to RUN with the vector fetch.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics): on Redirect_Valid, the instruction at the current PC is the delay slot.
  - IF/ID<= {Inst_In, PC+4, 1}.
  - Fetch_Count increments.
- Undefined: on Redirect_Valid, the instruction at the current PC is squashed.
  - IF/ID loads bubble.
  - Fetch_Count holds.
- Exc_Valid always squashes, regardless of the macro.

Test Plan:
- Reset then release; ROM returns 32'h20042f5b at 0, 32'h2405cfc7 at 4:
  - Inst_Addr 0 during BOOT, then 0,4,8.
  - IF_ID_Inst 32'h20042f5b with PC_Plus4=4, then 32'h2405cfc7 with PC_Plus4=8.
  - Fetch_Count 1,2.
- Stall held 3 cycles at PC=8:
  - Inst_Addr stays 8.
  - IF/ID and Fetch_Count frozen.
  - After release, PC=12 next edge.
- Redirect_Valid=1, Target=32'h00000034 at PC=0x18:
  - Next Inst_Addr=0x34.
  - With macro: IF_ID_Inst=word@0x18, Valid=1.
  - Without macro: Valid=0, Inst=0.
- Exc_Valid and Redirect_Valid and Stall all asserted together:
  - PC=0x80, IF_ID_Valid=0, Fetch_Count unchanged.
- Redirect_Target=32'h00000037:
  - PC=0x34.
  - Wraparound: force PC to 0xFFFFFFFC, next PC=0.
- Assert reset_n=0 asynchronously mid-cycle during a redirect:
  - Outputs reach reset values immediately.
  - Fetch resumes at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: PC register, ROM addressing and the IF/ID pipeline register.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the instruction after a taken branch as its delay slot.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR = 32'h00000080,
    parameter int          COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               Stall,
    input  logic               Redirect_Valid,
    input  logic [31:0]        Redirect_Target,
    input  logic               Exc_Valid,
    output logic [31:0]        Inst_Addr,
    input  logic [31:0]        Inst_In,
    output logic [31:0]        IF_ID_Inst,
    output logic [31:0]        IF_ID_PC_Plus4,
    output logic               IF_ID_Valid,
    output logic [COUNT_W-1:0] Fetch_Count
);

    localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [31:0] EXC_PC_W   = EXC_VECTOR & 32'hFFFF_FFFC;

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_inst;
    logic [31:0]        r_pc_plus4;
    logic               r_valid;
    logic [COUNT_W-1:0] r_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_keep_slot;
    logic        w_deliver;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_redirect_pc = Redirect_Target & 32'hFFFF_FFFC;

`ifdef BRANCH_DELAY_SLOT_EN
    assign w_keep_slot = 1'b1;
`else
    assign w_keep_slot = 1'b0;
`endif

    // The word at PC reaches ID on a plain advance, or on a redirect when it is the delay slot.
    assign w_deliver = !Redirect_Valid || w_keep_slot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC_W;
            r_inst     <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
            r_count    <= '0;
        end else if (Exc_Valid) begin
            r_state    <= RUN;
            r_pc       <= EXC_PC_W;
            r_inst     <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (r_state == BOOT) begin
            // ROM output is not trusted on the first edge: PC holds and IF/ID stays a bubble.
            r_state    <= RUN;
            r_inst     <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (!Stall) begin
            r_pc <= Redirect_Valid ? w_redirect_pc : w_pc_plus4;
            if (w_deliver) begin
                r_inst     <= Inst_In;
                r_pc_plus4 <= w_pc_plus4;
                r_valid    <= 1'b1;
                r_count    <= r_count + COUNT_W'(1);
            end else begin
                r_inst     <= 32'd0;
                r_pc_plus4 <= 32'd0;
                r_valid    <= 1'b0;
            end
        end
    end

    assign Inst_Addr      = r_pc;
    assign IF_ID_Inst     = r_inst;
    assign IF_ID_PC_Plus4 = r_pc_plus4;
    assign IF_ID_Valid    = r_valid;
    assign Fetch_Count    = r_count;

endmodule
